// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   dir_e    : counting direction of the shared period counter
//   mode_e   : edge-aligned or center-aligned counting
//   ch_width : width of a channel index, never less than one bit
package pwm_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Shared prescaler for pwm_multi.
// It counts 0..i_final_value and then wraps to 0. o_step is high during the
// cycle in which the count equals i_final_value.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_enable       : run/stop; the count is cleared while low
//   i_final_value  : terminal count, one step every i_final_value+1 clocks
//   o_step         : combinational step strobe (gated by i_enable)
module pwm_prescaler #(
    parameter int TIMER_BITS = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_enable,
    input  logic [TIMER_BITS-1:0] i_final_value,
    output logic                  o_step
);

    logic [TIMER_BITS-1:0] r_count;
    logic                  w_term;

    assign w_term = (r_count == i_final_value);
    assign o_step = i_enable & w_term;

    // If i_final_value drops below the running count, the count simply
    // keeps incrementing through its natural wrap before it matches again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (!i_enable || w_term) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TIMER_BITS'(1);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaler and one shared R-bit
// period counter drive CHANNELS comparators. Each channel owns a shadow duty
// (written any time) and an active duty (reloaded only at a period boundary).
// Optional feature macro: PWM_CENTER_ALIGN_EN adds up/down (center-aligned)
// counting selected by center_mode; without it the block is edge-aligned only.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : run/stop for prescaler, counter and outputs
//   final_value   : prescaler terminal count
//   center_mode   : 0 edge-aligned, 1 center-aligned (sampled at boundaries)
//   duty_wr       : single-cycle shadow duty write strobe
//   duty_ch       : channel addressed by the write
//   duty_data     : duty value, R+1 bits (2^R means always high)
//   pwm_out       : registered PWM outputs
//   period_start  : one-clock pulse when a new period begins
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int R          = 8,
    parameter int TIMER_BITS = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [TIMER_BITS-1:0]         final_value,
    input  logic                          center_mode,
    input  logic                          duty_wr,
    input  logic [ch_width(CHANNELS)-1:0] duty_ch,
    input  logic [R:0]                    duty_data,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic                          period_start
);

    localparam int            CHW     = ch_width(CHANNELS);
    localparam logic [R-1:0]  CNT_MAX = '1;

    logic                  w_step;
    logic                  w_boundary;
    logic [R-1:0]          r_cnt;
    logic [R-1:0]          w_cnt_next;
    logic [CHANNELS-1:0]   r_pwm;
    logic                  r_period_start;
    logic [R:0]            r_shadow   [CHANNELS];
    logic [R:0]            r_active   [CHANNELS];
    logic [R:0]            w_act_next [CHANNELS];
    logic [CHANNELS-1:0]   w_hit;
    logic [CHANNELS-1:0]   w_cmp;
    logic                  w_ch_ok;

    pwm_prescaler #(
        .TIMER_BITS (TIMER_BITS)
    ) u_prescaler (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_enable      (enable),
        .i_final_value (final_value),
        .o_step        (w_step)
    );

`ifdef PWM_CENTER_ALIGN_EN
    dir_e  r_dir;
    dir_e  w_dir_next;
    mode_e r_mode;

    // The mode register holds MODE_EDGE out of reset and while stopped, so
    // the first step from the all-ones counter always wraps to 0 as an edge
    // boundary; the requested mode is then picked up at that boundary.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        w_boundary = 1'b0;
        if (w_step) begin
            if (r_mode == MODE_CENTER) begin
                if (r_dir == DIR_UP) begin
                    if (r_cnt == CNT_MAX) begin
                        w_dir_next = DIR_DOWN;
                        w_cnt_next = r_cnt - R'(1);
                    end else begin
                        w_cnt_next = r_cnt + R'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt - R'(1);
                    if (r_cnt == R'(1)) begin
                        w_boundary = 1'b1;
                        w_dir_next = DIR_UP;
                    end
                end
            end else begin
                w_cnt_next = r_cnt + R'(1);
                w_dir_next = DIR_UP;
                w_boundary = (r_cnt == CNT_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir  <= DIR_UP;
            r_mode <= MODE_EDGE;
        end else if (!enable) begin
            r_dir  <= DIR_UP;
            r_mode <= MODE_EDGE;
        end else begin
            r_dir <= w_dir_next;
            if (w_boundary) begin
                r_mode <= center_mode ? MODE_CENTER : MODE_EDGE;
            end
        end
    end
`else
    logic w_unused_center;
    assign w_unused_center = center_mode;

    always_comb begin
        w_cnt_next = r_cnt;
        w_boundary = 1'b0;
        if (w_step) begin
            w_cnt_next = r_cnt + R'(1);
            w_boundary = (r_cnt == CNT_MAX);
        end
    end
`endif

    assign w_ch_ok = (32'(duty_ch) < 32'(CHANNELS));

    // A write landing on the boundary cycle goes straight into the active
    // duty so it is not lost for a whole period. The comparator uses the
    // post-step counter and duty so outputs line up with period_start.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_hit[i]      = duty_wr && w_ch_ok && (duty_ch == CHW'(i));
            w_act_next[i] = r_active[i];
            if (w_boundary) begin
                w_act_next[i] = w_hit[i] ? duty_data : r_shadow[i];
            end
            w_cmp[i] = ({1'b0, w_cnt_next} < w_act_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_hit[i]) begin
                    r_shadow[i] <= duty_data;
                end
                r_active[i] <= w_act_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt          <= CNT_MAX;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else if (!enable) begin
            r_cnt          <= CNT_MAX;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_period_start <= w_boundary;
            if (w_step) begin
                r_pwm <= w_cmp;
            end
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int RB = 4;
    localparam int TB = 15;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [TB-1:0] final_value;
    logic          center_mode;
    logic          duty_wr;
    logic [1:0]    duty_ch;
    logic [RB:0]   duty_data;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    int n_cmp = 0;
    int n_bad = 0;
    int hi [CH];
    int nps;
    int cur_fv;
    int n;

    pwm_multi #(
        .CHANNELS   (CH),
        .R          (RB),
        .TIMER_BITS (TB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .final_value  (final_value),
        .center_mode  (center_mode),
        .duty_wr      (duty_wr),
        .duty_ch      (duty_ch),
        .duty_data    (duty_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int ch, input int val);
        duty_ch   = 2'(ch);
        duty_data = 5'(val);
        duty_wr   = 1'b1;
        @(negedge clk);
        duty_wr   = 1'b0;
    endtask

    // Wait (bounded) for the negedge at which period_start is visible.
    task automatic sync_ps(input int lim);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < lim);
        chk("sync_ps", int'(period_start), 1);
    endtask

    // Called at a negedge showing period_start; samples len negedges,
    // optionally pulsing a duty write at sample wr_at, and ends on the
    // negedge where the next period_start is expected.
    task automatic measure(input int len, input int wr_at, input int wr_ch, input int wr_val);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        nps = 0;
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
            nps += int'(period_start);
            duty_wr = 1'b0;
            if (k == wr_at) begin
                duty_ch   = 2'(wr_ch);
                duty_data = 5'(wr_val);
                duty_wr   = 1'b1;
            end
            @(negedge clk);
        end
        duty_wr = 1'b0;
        chk("ps_in_period", nps, 1);
        chk("ps_at_end", int'(period_start), 1);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        final_value = '0;
        center_mode = 1'b0;
        duty_wr     = 1'b0;
        duty_ch     = '0;
        duty_data   = '0;
        cur_fv      = 2;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ps", int'(period_start), 0);
        reset_n = 1'b1;
        @(negedge clk);

        wr(0, 0);
        wr(1, 4);
        wr(2, 8);
        wr(3, 16);
        chk("idle_pwm", int'(pwm_out), 0);
        final_value = TB'(cur_fv);
        enable = 1'b1;
        sync_ps(100);

        // Basic edge-aligned period: 48 clk.
        measure(48, -1, 0, 0);
        chk("p1_ch0", hi[0], 0);
        chk("p1_ch1", hi[1], 12);
        chk("p1_ch2", hi[2], 24);
        chk("p1_ch3", hi[3], 48);

        // Mid-period write: takes effect only from the next boundary.
        measure(48, 10, 1, 12);
        chk("p2_ch1_old", hi[1], 12);

        // Write in the boundary cycle ending this period: bypass.
        measure(48, 47, 2, 4);
        chk("p3_ch1_new", hi[1], 36);
        chk("p3_ch2_old", hi[2], 24);

        measure(48, -1, 0, 0);
        chk("p4_ch2_bypass", hi[2], 12);
        chk("p4_ch1", hi[1], 36);

`ifdef PWM_CENTER_ALIGN_EN
        cur_fv      = 0;
        final_value = '0;
        center_mode = 1'b1;
        wr(0, 8);
        sync_ps(200);
        measure(30, -1, 0, 0);
        chk("c1_ch0", hi[0], 15);
        chk("c1_ch1", hi[1], 23);
        chk("c1_ch2", hi[2], 7);
        chk("c1_ch3", hi[3], 30);
        center_mode = 1'b0;
        measure(30, -1, 0, 0);
        chk("c2_ch0_still_center", hi[0], 15);
        measure(16, -1, 0, 0);
        chk("c3_ch0_edge", hi[0], 8);
        chk("c3_ch3_edge", hi[3], 16);
`else
        center_mode = 1'b1;
        measure(48, -1, 0, 0);
        chk("ign_center_ch2", hi[2], 12);
        chk("ign_center_ch3", hi[3], 48);
        center_mode = 1'b0;
`endif

        // Enable dropped mid-period, then re-raised.
        repeat (5) @(negedge clk);
        chk("pre_dis_ch3", int'(pwm_out[3]), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_pwm", int'(pwm_out), 0);
        repeat (4) @(negedge clk);
        chk("dis_pwm_hold", int'(pwm_out), 0);
        chk("dis_ps", int'(period_start), 0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 100);
        chk("en_restart_lat", n, cur_fv + 1);
        chk("en_restart_ch3", int'(pwm_out[3]), 1);
        measure(16 * (cur_fv + 1), -1, 0, 0);
        chk("en_ch1", hi[1], 12 * (cur_fv + 1));

        // Asynchronous reset mid-period.
        repeat (5) @(negedge clk);
        chk("pre_rst_ch3", int'(pwm_out[3]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_ps", int'(period_start), 0);
        @(negedge clk);
        reset_n = 1'b1;
        sync_ps(100);
        measure(16 * (cur_fv + 1), -1, 0, 0);
        chk("post_rst_ch3", hi[3], 0);
        chk("post_rst_ch1", hi[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel successor to the single-channel prescaled PWM generator. It drives CHANNELS outputs from one shared prescaler and one shared R-bit period counter. Each channel has its own double-buffered duty register, which takes new values only at a period boundary. Center-aligned (up/down) counting can be compiled in as a selectable mode. The block sits between the register/control logic that writes duties and the output pins or gate drivers.

## Interface
- CHANNELS, 4, number of PWM outputs (≥1)
- R, 8, counter resolution in bits; duty is R+1 bits so 2^R means 100 %
- TIMER_BITS, 15, prescaler width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run/stop for prescaler, counter and outputs
- final_value  in  TIMER_BITS  prescaler terminal count; one step every final_value+1 clk
- center_mode  in  1  0 edge-aligned, 1 center-aligned (needs PWM_CENTER_ALIGN_EN)
- duty_wr  in  1  single-cycle write strobe for the shadow duty
- duty_ch  in  max(1,$clog2(CHANNELS))  target channel of the write
- duty_data  in  R+1  duty value to write
- pwm_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-clk pulse when a new period begins and duties reload

## Operation
- Prescaler counts 0..final_value, then wraps to 0. `step` is asserted in the cycle count==final_value. final_value=0 gives a step every clk.
- Edge mode: on each step the counter goes 0→2^R−1 and wraps to 0. Period is 2^R steps.
- Center mode: on each step the counter goes up 0→2^R−1, then down to 0. Direction flips at the extremes. Period is 2·(2^R−1) steps.
- Boundary = a step where the next counter value is 0 (edge mode), or where the counter reaches 0 while counting down (center mode).
- At a boundary:
  - every active_duty[i] loads shadow_duty[i];
  - center_mode is sampled into an internal mode register;
  - period_start pulses.
- On each step, pwm_out[i] is updated with (current counter < active_duty[i]), compared at R+1 bits.
  - duty=0 gives a constant 0; duty ≥ 2^R gives a constant 1.
- Writes:
  - duty_wr loads shadow_duty[duty_ch] with duty_data in any cycle.
  - duty_ch ≥ CHANNELS is ignored.
  - A write in the same cycle as a boundary bypasses: active_duty[duty_ch] takes the new duty_data.
- enable low:
  - prescaler cleared;
  - counter set to all-ones, direction up;
  - pwm_out forced to 0, no period_start;
  - shadow and active duties retained.
- Rising enable behaves like reset release: the first step is a boundary, so counting restarts at 0 with fresh duties.
- Reset values:
  - counter all-ones, direction up, prescaler 0, mode 0;
  - shadow and active duties 0;
  - pwm_out 0, period_start 0.
- Changing final_value mid-count takes effect immediately. If the prescaler is already above the new value, it runs to its 2^TIMER_BITS−1 wrap before stepping again.

## Timing
- pwm_out and period_start change 1 clk after the step cycle.
- Edge period = 2^R·(final_value+1) clk. Center period = 2·(2^R−1)·(final_value+1) clk.
- Write-to-output latency: until the next boundary, plus 1 clk.
- Reset asserted mid-period clears everything asynchronously. No partial pulse continues.

## Configuration
- PWM_CENTER_ALIGN_EN defined:
  - up/down counter, direction flop and mode register are present;
  - center_mode is honoured.
- PWM_CENTER_ALIGN_EN undefined:
  - edge-aligned only;
  - center_mode is ignored, and no direction or mode flops are built.

## Structure
- Shared package pwm_pkg:
  - direction enum (DIR_UP, DIR_DOWN);
  - mode enum (MODE_EDGE, MODE_CENTER);
  - function computing the channel-index width.
- One sub-module: pwm_prescaler, holding the prescaler counter with enable, final_value and step output.
- The counter, duty banks and comparators stay in pwm_multi, generated per channel.

## Test plan
- R=4, CHANNELS=4, final_value=2, edge mode, duties {0,4,8,16} → ch0 constant 0; ch1 high for 12 of 48 clk; ch2 high for 24 of 48; ch3 constant 1; period_start every 48 clk.
- Write ch1=12 mid-period → ch1 keeps 4 for the rest of the period, then shows 12 high steps from the next boundary; no glitch.
- Write ch2 in the exact boundary cycle → new value applied in that same period (bypass).
- center_mode=1 (macro defined), R=4, final_value=0, duty 8 → period 30 clk, high for 15 clk total, centred on counter=0; center_mode toggled mid-period takes effect only at the next boundary.
- enable dropped mid-period → pwm_out 0 within 1 clk; re-raised → first period_start at the first step, counting from 0.
- reset_n pulsed mid-period → all outputs 0 asynchronously; duties read back as 0 (outputs stay low after release).
